// File: rtl/mem_march_bist_if.sv
// Single-port SRAM access bundle shared by the BIST initiator (master)
// and the memory or its test-mode mux (slave).
interface mem_march_bist_if #(
    parameter int WIDTH      = 64,
    parameter int ADDR_WIDTH = 6
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      wdata;
    logic                  wr_en;
    logic                  rd_en;
    logic [WIDTH-1:0]      rdata;

    modport master (
        output addr,
        output wdata,
        output wr_en,
        output rd_en,
        input  rdata
    );

    modport slave (
        input  addr,
        input  wdata,
        input  wr_en,
        input  rd_en,
        output rdata
    );
endinterface

// File: rtl/mem_march_bist.sv
// March BIST initiator: w(P) up, r(P)w(~P) up, r(~P)w(P) down, r(P) down,
// with saturating error count and first-failure capture.
module mem_march_bist #(
    parameter int               WIDTH      = 64,
    parameter int               DEPTH      = 64,
    parameter int               ADDR_WIDTH = 6,
    parameter logic [WIDTH-1:0] PATTERN    = WIDTH'(64'hAAAA_AAAA_AAAA_AAAA),
    parameter int               CNT_W      = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    mem_march_bist_if.master      mem,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic                  fail_o,
    output logic [CNT_W-1:0]      err_cnt_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic [WIDTH-1:0]      fail_data_o
);

    typedef enum logic [3:0] {
        IDLE,
        M0_WR,
        M1_RD,
        M1_CHK,
        M2_RD,
        M2_CHK,
        M3_RD,
        M3_CHK,
        DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_A = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ZERO_A = '0;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]      err_cnt_q, err_cnt_d;
    logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
    logic [WIDTH-1:0]      fail_data_q, fail_data_d;
    logic                  pass_q, pass_d;
    logic                  fail_q, fail_d;

    logic                  busy;
    logic                  done;
    logic                  rd_en;
    logic                  wr_en;
    logic [WIDTH-1:0]      wdata;
    logic                  chk_en;
    logic [WIDTH-1:0]      exp_data;
    logic                  mismatch;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            err_cnt_q   <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            err_cnt_q   <= err_cnt_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
        end
    end

    // Read data arrives in the CHK cycle, one cycle after the RD cycle at the same address.
    assign mismatch = chk_en && (mem.rdata != exp_data);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        err_cnt_d   = err_cnt_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        pass_d      = pass_q;
        fail_d      = fail_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d     = M0_WR;
                    addr_d      = '0;
                    err_cnt_d   = '0;
                    fail_addr_d = '0;
                    fail_data_d = '0;
                    pass_d      = 1'b0;
                    fail_d      = 1'b0;
                end
            end
            M0_WR: begin
                if (addr_q == LAST_A) begin
                    state_d = M1_RD;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            M1_RD: state_d = M1_CHK;
            M1_CHK: begin
                if (addr_q == LAST_A) begin
                    state_d = M2_RD;
                end else begin
                    state_d = M1_RD;
                    addr_d  = addr_q + 1'b1;
                end
            end
            M2_RD: state_d = M2_CHK;
            M2_CHK: begin
                if (addr_q == ZERO_A) begin
                    state_d = M3_RD;
                    addr_d  = LAST_A;
                end else begin
                    state_d = M2_RD;
                    addr_d  = addr_q - 1'b1;
                end
            end
            M3_RD: state_d = M3_CHK;
            M3_CHK: begin
                if (addr_q == ZERO_A) begin
                    state_d = DONE;
                end else begin
                    state_d = M3_RD;
                    addr_d  = addr_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                pass_d  = (err_cnt_q == '0);
                fail_d  = (err_cnt_q != '0);
            end
            default: state_d = IDLE;
        endcase

        if (mismatch) begin
            err_cnt_d = sat_inc(err_cnt_q);
            // The counter only ever grows within a run, so zero marks the first failure.
            if (err_cnt_q == '0) begin
                fail_addr_d = addr_q;
                fail_data_d = mem.rdata;
            end
        end
    end

    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        rd_en    = 1'b0;
        wr_en    = 1'b0;
        wdata    = '0;
        chk_en   = 1'b0;
        exp_data = PATTERN;

        case (state_q)
            M0_WR: begin
                busy  = 1'b1;
                wr_en = 1'b1;
                wdata = PATTERN;
            end
            M1_RD, M2_RD, M3_RD: begin
                busy  = 1'b1;
                rd_en = 1'b1;
            end
            M1_CHK: begin
                busy     = 1'b1;
                wr_en    = 1'b1;
                wdata    = ~PATTERN;
                chk_en   = 1'b1;
                exp_data = PATTERN;
            end
            M2_CHK: begin
                busy     = 1'b1;
                wr_en    = 1'b1;
                wdata    = PATTERN;
                chk_en   = 1'b1;
                exp_data = ~PATTERN;
            end
            M3_CHK: begin
                busy     = 1'b1;
                chk_en   = 1'b1;
                exp_data = PATTERN;
            end
            DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign mem.addr    = addr_q;
    assign mem.wdata   = wdata;
    assign mem.wr_en   = wr_en;
    assign mem.rd_en   = rd_en;

    assign busy_o      = busy;
    assign done_o      = done;
    assign pass_o      = pass_q;
    assign fail_o      = fail_q;
    assign err_cnt_o   = err_cnt_q;
    assign fail_addr_o = fail_addr_q;
    assign fail_data_o = fail_data_q;

endmodule

// File: tb/tb_mem_march_bist.sv
// Bench for mem_march_bist: one default instance on a behavioural SRAM with an
// optional stuck-at bit, plus a CNT_W=2 instance on an all-zero memory.
module tb_mem_march_bist;

    localparam logic [63:0] P = 64'hAAAA_AAAA_AAAA_AAAA;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start_a, start_b, sel, fault_a;

    logic       busy_a, done_a, pass_a, fail_a;
    logic [7:0] err_a;
    logic [5:0] faddr_a;
    logic [63:0] fdata_a;

    logic       busy_b, done_b, pass_b, fail_b;
    logic [1:0] err_b;
    logic [5:0] faddr_b;
    logic [63:0] fdata_b;

    mem_march_bist_if #(.WIDTH(64), .ADDR_WIDTH(6)) if_a ();
    mem_march_bist_if #(.WIDTH(64), .ADDR_WIDTH(6)) if_b ();

    mem_march_bist dut_a (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .start_i    (start_a),
        .mem        (if_a),
        .busy_o     (busy_a),
        .done_o     (done_a),
        .pass_o     (pass_a),
        .fail_o     (fail_a),
        .err_cnt_o  (err_a),
        .fail_addr_o(faddr_a),
        .fail_data_o(fdata_a)
    );

    mem_march_bist #(.CNT_W(2)) dut_b (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .start_i    (start_b),
        .mem        (if_b),
        .busy_o     (busy_b),
        .done_o     (done_b),
        .pass_o     (pass_b),
        .fail_o     (fail_b),
        .err_cnt_o  (err_b),
        .fail_addr_o(faddr_b),
        .fail_data_o(fdata_b)
    );

    // Synchronous SRAM model; optional stuck-at-0 on bit 3 of word 17
    logic [63:0] mem_a [64];
    logic [63:0] rdata_a;
    always @(posedge clk) begin
        if (if_a.wr_en) mem_a[if_a.addr] <= if_a.wdata;
        if (if_a.rd_en)
            rdata_a <= (fault_a && if_a.addr == 6'd17) ? (mem_a[if_a.addr] & ~64'h8)
                                                       : mem_a[if_a.addr];
    end
    assign if_a.rdata = rdata_a;
    assign if_b.rdata = '0;

    logic        s_busy, s_done, s_pass, s_fail, s_wr, s_rd;
    logic [7:0]  s_err;
    logic [5:0]  s_addr, s_faddr;
    logic [63:0] s_wdata, s_fdata;
    assign s_busy  = sel ? busy_b       : busy_a;
    assign s_done  = sel ? done_b       : done_a;
    assign s_pass  = sel ? pass_b       : pass_a;
    assign s_fail  = sel ? fail_b       : fail_a;
    assign s_wr    = sel ? if_b.wr_en   : if_a.wr_en;
    assign s_rd    = sel ? if_b.rd_en   : if_a.rd_en;
    assign s_err   = sel ? {6'd0, err_b} : err_a;
    assign s_addr  = sel ? if_b.addr    : if_a.addr;
    assign s_faddr = sel ? faddr_b      : faddr_a;
    assign s_wdata = sel ? if_b.wdata   : if_a.wdata;
    assign s_fdata = sel ? fdata_b      : fdata_a;

    int n_chk = 0;
    int n_pass = 0;
    int proto_bad = 0;
    int done_cnt = 0;
    logic       prev_rd = 1'b0;
    logic [5:0] prev_addr = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rd = 1'b0;
        end else begin
            if (s_done) done_cnt++;
            if (s_wr && s_rd) proto_bad++;
            if (!s_wr && s_wdata != 64'd0) proto_bad++;
            if (prev_rd && (s_rd || !s_busy || s_addr != prev_addr)) proto_bad++;
            prev_rd   = s_rd;
            prev_addr = s_addr;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    endtask

    typedef struct {
        string       name;
        bit          inst;
        bit          fault;
        int          len;
        bit          pass;
        bit          fail;
        int          err;
        logic [5:0]  faddr;
        logic [63:0] fdata;
    } vec_t;

    vec_t vecs[4];

    task automatic apply_vec(input vec_t v);
        int len, m0_bad, nrd, nwr, dbase;
        sel     = v.inst;
        fault_a = v.fault;
        @(negedge clk);
        #1 dbase = done_cnt;
        if (v.inst) start_b = 1'b1;
        else        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        len = 0; m0_bad = 0; nrd = 0; nwr = 0;
        while (s_busy && len < 1000) begin
            len++;
            if (len <= 64 && !(s_wr && !s_rd && s_addr == 6'(len - 1) && s_wdata == P)) m0_bad++;
            if (s_rd) nrd++;
            if (s_wr) nwr++;
            @(negedge clk);
        end
        chk({v.name, " done_pulse"}, s_done, 1);
        chk({v.name, " busy_len"}, len, v.len);
        chk({v.name, " m0_seq"}, m0_bad, 0);
        chk({v.name, " reads"}, nrd, 192);
        chk({v.name, " writes"}, nwr, 192);
        @(negedge clk);
        chk({v.name, " done_low"}, s_done, 0);
        chk({v.name, " pass"}, s_pass, v.pass);
        chk({v.name, " fail"}, s_fail, v.fail);
        chk({v.name, " err_cnt"}, s_err, v.err);
        chk({v.name, " fail_addr"}, s_faddr, v.faddr);
        chk({v.name, " fail_data"}, s_fdata, v.fdata);
        #1 chk({v.name, " done_count"}, done_cnt - dbase, 1);
    endtask

    int len, dbase;

    initial begin
        vecs[0] = '{"clean", 1'b0, 1'b0, 448, 1'b1, 1'b0, 0, 6'd0, 64'h0};
        vecs[1] = '{"stuck17", 1'b0, 1'b1, 448, 1'b0, 1'b1, 2, 6'd17, 64'hAAAA_AAAA_AAAA_AAA2};
        vecs[2] = '{"zeros_sat", 1'b1, 1'b0, 448, 1'b0, 1'b1, 3, 6'd0, 64'h0};
        vecs[3] = '{"after_reset", 1'b0, 1'b0, 448, 1'b1, 1'b0, 0, 6'd0, 64'h0};

        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; sel = 1'b0; fault_a = 1'b0;
        #22;
        chk("rst busy", busy_a, 0);
        chk("rst done", done_a, 0);
        chk("rst pass", pass_a, 0);
        chk("rst fail", fail_a, 0);
        chk("rst err", err_a, 0);
        chk("rst faddr", faddr_a, 0);
        chk("rst fdata", fdata_a, 0);
        chk("rst addr", if_a.addr, 0);
        chk("rst wdata", if_a.wdata, 0);
        chk("rst wr", if_a.wr_en, 0);
        chk("rst rd", if_a.rd_en, 0);
        chk("rst err_b", err_b, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 3; i++) apply_vec(vecs[i]);

        // Start pulses mid-run are ignored; start held through DONE restarts next cycle
        sel = 1'b0; fault_a = 1'b1;
        @(negedge clk);
        #1 start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        len = 0;
        while (s_busy && len < 1000) begin
            len++;
            start_a = (len == 10 || len == 300 || len >= 440);
            @(negedge clk);
        end
        chk("ign busy_len", len, 448);
        chk("ign done", s_done, 1);
        @(negedge clk);
        chk("hold idle_gap busy", s_busy, 0);
        chk("hold prev fail", s_fail, 1);
        chk("hold prev err", s_err, 2);
        @(negedge clk);
        chk("hold restart busy", s_busy, 1);
        chk("hold clr err", s_err, 0);
        chk("hold clr fail", s_fail, 0);
        chk("hold clr pass", s_pass, 0);
        chk("hold clr faddr", s_faddr, 0);
        chk("hold clr fdata", s_fdata, 0);
        start_a = 1'b0;
        len = 0;
        while (s_busy && len < 1000) begin
            len++;
            @(negedge clk);
        end
        chk("hold run2 len", len, 448);
        @(negedge clk);
        chk("hold run2 err", s_err, 2);
        chk("hold run2 fail", s_fail, 1);
        chk("hold run2 faddr", s_faddr, 17);

        // Asynchronous abort in the middle of march element M1
        sel = 1'b0; fault_a = 1'b0;
        @(negedge clk);
        #1 dbase = done_cnt;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        len = 1;
        while (len < 100 && s_busy) begin
            @(negedge clk);
            len++;
        end
        chk("abort pre wr", s_wr, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort busy", busy_a, 0);
        chk("abort wr", if_a.wr_en, 0);
        chk("abort rd", if_a.rd_en, 0);
        chk("abort addr", if_a.addr, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("abort stays idle", busy_a, 0);
        #1 chk("abort no done", done_cnt - dbase, 0);

        apply_vec(vecs[3]);

        chk("protocol", proto_bad, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
